// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between the LC-3 control FSM / memory and the access sequencer.
// master = the sequencer, slave = control FSM, memory and MDR register side.
interface mem_access_ctrl_if;
   logic        MIO_EN;
   logic        R_W;
   logic [15:0] MAR;
   logic [15:0] MDR_In;
   logic        Mem_Req;
   logic        Mem_Write;
   logic [15:0] Mem_Addr;
   logic [15:0] Mem_WData;
   logic        Mem_Ack;
   logic [15:0] Mem_RData;
   logic [15:0] MDR_D;
   logic        MDR_WE;
   logic        R;
   logic        Err;
   logic        Err_Clr;

   modport master (
      input  MIO_EN, R_W, MAR, MDR_In, Mem_Ack, Mem_RData, Err_Clr,
      output Mem_Req, Mem_Write, Mem_Addr, Mem_WData, MDR_D, MDR_WE, R, Err
   );

   modport slave (
      output MIO_EN, R_W, MAR, MDR_In, Mem_Ack, Mem_RData, Err_Clr,
      input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData, MDR_D, MDR_WE, R, Err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: req/ack handshake with timeout, feeding the negedge MDR
// register with read data and returning the one-cycle ready pulse R.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic              Clk,
   input logic              Reset,
   mem_access_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  count;
   logic        ack_hit, to_hit;

   logic        mem_req_q, mem_write_q, mdr_we_q, r_q, err_q;
   logic [15:0] mem_addr_q, mem_wdata_q, mdr_d_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Ack is checked before the timeout so a late ack still completes normally.
   always_comb begin
      state_nxt = state;
      ack_hit   = 1'b0;
      to_hit    = 1'b0;
      case (state)
         IDLE: if (bus.MIO_EN) state_nxt = REQ;
         REQ: begin
            if (bus.Mem_Ack) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (count == 8'(TIMEOUT - 1)) begin
               to_hit    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are registered copies of the next state so they are glitch-free
   // and drop asynchronously with Reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count       <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 16'h0000;
         mdr_d_q     <= 16'h0000;
         mdr_we_q    <= 1'b0;
         r_q         <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_req_q <= (state_nxt == REQ);
         r_q       <= (state_nxt == DONE);
         mdr_we_q  <= (state == REQ) && (state_nxt == DONE) && !mem_write_q;

         if (state == IDLE && bus.MIO_EN) begin
            mem_addr_q  <= bus.MAR;
            mem_wdata_q <= bus.MDR_In;
            mem_write_q <= bus.R_W;
            count       <= 8'd0;
         end

         if (state == REQ) begin
            if (ack_hit) begin
               if (!mem_write_q) mdr_d_q <= bus.Mem_RData;
            end else if (to_hit) begin
               if (!mem_write_q) mdr_d_q <= 16'h0000;
            end else begin
               count <= count + 8'd1;
            end
         end

         if (to_hit)           err_q <= 1'b1;
         else if (bus.Err_Clr) err_q <= 1'b0;
      end
   end

   assign bus.Mem_Req   = mem_req_q;
   assign bus.Mem_Write = mem_write_q;
   assign bus.Mem_Addr  = mem_addr_q;
   assign bus.Mem_WData = mem_wdata_q;
   assign bus.MDR_D     = mdr_d_q;
   assign bus.MDR_WE    = mdr_we_q;
   assign bus.R         = r_q;
   assign bus.Err       = err_q;

endmodule
